// File: rtl/adc_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : adc_capture_writer
// Brief    : Pre/post-trigger ADC capture into a circular sample buffer.
//            Keeps PRETRIG samples ahead of a level-crossing (or forced)
//            trigger, then fills the remainder of the buffer and flags
//            data_ready with the address of the oldest captured sample.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture_writer #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 8,
  parameter int PRETRIG = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              arm,
  input  logic [DATA_W-1:0] trig_level,
  input  logic              trig_edge,
  input  logic              force_trig,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              data_ready,
  output logic [ADDR_W-1:0] start_addr,
  output logic              busy
);

  localparam int DEPTH  = 1 << ADDR_W;
  // Writes still owed after the trigger sample itself.
  localparam int POST_N = DEPTH - PRETRIG - 1;
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRETRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'(POST_N - 1);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRETRIG);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_ARMED = 3'd2,
    S_POST  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W-1:0]   r_cnt;
  logic [DATA_W-1:0]   r_prev;
  logic                r_have_prev;
  logic                r_force;
  logic                r_last;
  logic                w_accept_arm;
  logic                w_write;
  logic                w_trig;
  logic                w_edge;
  logic                w_last_write;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state decode, trigger detection and write qualification.
  always_comb begin
    w_next       = r_state;
    w_accept_arm = 1'b0;
    w_trig       = 1'b0;
    busy         = (r_state == S_PRE) || (r_state == S_ARMED) || (r_state == S_POST);
    w_write      = busy && adc_valid;
    // Edge needs a predecessor sample from this capture.
    if (trig_edge)
      w_edge = r_have_prev && (r_prev > trig_level) && (adc_data <= trig_level);
    else
      w_edge = r_have_prev && (r_prev < trig_level) && (adc_data >= trig_level);
    case (r_state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          w_accept_arm = 1'b1;
          w_next       = (PRETRIG == 0) ? S_ARMED : S_PRE;
        end
      end
      S_PRE: begin
        if (adc_valid && (r_cnt == PRE_LAST)) w_next = S_ARMED;
      end
      S_ARMED: begin
        if (adc_valid && (r_force || w_edge)) begin
          w_trig = 1'b1;
          w_next = (POST_N == 0) ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (adc_valid && (r_cnt == POST_LAST)) w_next = S_DONE;
      end
      default: w_next = S_IDLE;
    endcase
    w_last_write = w_write && (w_next == S_DONE);
  end

  // Write datapath, pointer, counters, force latch and capture status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      data_ready  <= 1'b0;
      start_addr  <= '0;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_prev      <= '0;
      r_have_prev <= 1'b0;
      r_force     <= 1'b0;
      r_last      <= 1'b0;
    end else begin
      wr_en  <= w_write;
      r_last <= w_last_write;
      if (w_write) begin
        wr_addr     <= r_ptr;
        wr_data     <= adc_data;
        r_ptr       <= r_ptr + 1'b1;
        r_prev      <= adc_data;
        r_have_prev <= 1'b1;
      end
      if (w_accept_arm) begin
        r_ptr       <= '0;
        r_cnt       <= '0;
        r_have_prev <= 1'b0;
        r_force     <= 1'b0;
        data_ready  <= 1'b0;
      end else if (r_last) begin
        data_ready  <= 1'b1;
      end
      if (w_write && (r_state == S_PRE))
        r_cnt <= (r_cnt == PRE_LAST) ? '0 : r_cnt + 1'b1;
      if (w_write && (r_state == S_POST))
        r_cnt <= r_cnt + 1'b1;
      if (w_trig) begin
        r_cnt      <= '0;
        r_force    <= 1'b0;
        start_addr <= r_ptr - PRE_OFS;
      end else if ((r_state == S_ARMED) && force_trig) begin
        r_force    <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture_writer
// Brief    : Directed bench for adc_capture_writer (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture_writer;

  logic       clk;
  logic       reset;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       arm;
  logic [7:0] trig_level;
  logic       trig_edge;
  logic       force_trig;
  logic       wr_en;
  logic [8:0] wr_addr;
  logic [7:0] wr_data;
  logic       data_ready;
  logic [8:0] start_addr;
  logic       busy;

  int vectors;
  int miscompares;
  int wr_cnt;
  int snap;

  adc_capture_writer #(.ADDR_W(9), .DATA_W(8), .PRETRIG(64)) dut (
    .clk        (clk),
    .reset      (reset),
    .adc_data   (adc_data),
    .adc_valid  (adc_valid),
    .arm        (arm),
    .trig_level (trig_level),
    .trig_edge  (trig_edge),
    .force_trig (force_trig),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .data_ready (data_ready),
    .start_addr (start_addr),
    .busy       (busy)
  );

  // Free-running 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count buffer writes on the falling edge.
  always @(negedge clk) if (wr_en === 1'b1) wr_cnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one cycle of inputs, then look at outputs 1 ns after the edge.
  task automatic step(input logic v, input logic [7:0] d, input logic a, input logic f);
    adc_valid  = v;
    adc_data   = d;
    arm        = a;
    force_trig = f;
    @(posedge clk);
    #1;
    adc_valid  = 1'b0;
    arm        = 1'b0;
    force_trig = 1'b0;
  endtask

  initial begin
    vectors = 0; miscompares = 0; wr_cnt = 0; snap = 0;
    reset = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0;
    trig_level = '0; trig_edge = 1'b0; force_trig = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_data_ready", data_ready, 0);
    chk("rst_start_addr", start_addr, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step(1'b1, 8'd9, 1'b0, 1'b0);
    chk("idle_no_write", wr_en, 0);

    // Rising trigger on a ramp: T=100, start 36, final write at 35.
    trig_level = 8'd100; trig_edge = 1'b0;
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("A_busy_after_arm", busy, 1);
    snap = wr_cnt;
    for (int v = 0; v < 100; v++) begin
      step(1'b1, 8'(v), 1'b0, 1'b0);
      if (v == 0) begin
        chk("A_first_wr_en", wr_en, 1);
        chk("A_first_addr", wr_addr, 0);
      end
    end
    step(1'b1, 8'd100, 1'b0, 1'b0);
    chk("A_trig_addr", wr_addr, 100);
    chk("A_trig_data", wr_data, 100);
    chk("A_start_addr", start_addr, 36);
    for (int i = 1; i <= 447; i++) step(1'b1, 8'((100 + i) & 255), 1'b0, 1'b0);
    chk("A_last_addr", wr_addr, 35);
    chk("A_ready_not_yet", data_ready, 0);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("A_data_ready", data_ready, 1);
    chk("A_not_busy", busy, 0);
    chk("A_write_count", wr_cnt - snap, 548);
    step(1'b1, 8'd7, 1'b0, 1'b0);
    chk("A_done_no_write", wr_en, 0);
    chk("A_ready_holds", data_ready, 1);

    // Falling trigger on a descending ramp: value 128 at address 127.
    trig_level = 8'd128; trig_edge = 1'b1;
    step(1'b0, 8'd0, 1'b1, 1'b0);
    chk("B_ready_cleared", data_ready, 0);
    chk("B_busy", busy, 1);
    for (int k = 0; k < 127; k++) step(1'b1, 8'(255 - k), 1'b0, 1'b0);
    step(1'b1, 8'd128, 1'b0, 1'b0);
    chk("B_trig_addr", wr_addr, 127);
    chk("B_trig_data", wr_data, 128);
    chk("B_start_addr", start_addr, 63);
    for (int i = 1; i < 200; i++) step(1'b1, 8'((127 - i) & 255), 1'b0, 1'b0);

    // Reset in the middle of POST.
    #2 reset = 1'b1;
    #1;
    chk("R_wr_en", wr_en, 0);
    chk("R_wr_addr", wr_addr, 0);
    chk("R_wr_data", wr_data, 0);
    chk("R_start_addr", start_addr, 0);
    chk("R_busy", busy, 0);
    chk("R_data_ready", data_ready, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b1, 8'd5, 1'b0, 1'b0);
    chk("R_idle_no_write", wr_en, 0);
    chk("R_ready_low", data_ready, 0);

    // Forced trigger: arm+force in IDLE and force in PRE must both do nothing.
    trig_level = 8'd100; trig_edge = 1'b0;
    step(1'b0, 8'd0, 1'b1, 1'b1);
    for (int k = 0; k < 70; k++) step(1'b1, 8'd50, 1'b0, (k == 10));
    step(1'b0, 8'd0, 1'b0, 1'b1);
    chk("C_force_gap", wr_en, 0);
    step(1'b1, 8'd50, 1'b0, 1'b0);
    chk("C_trig_addr", wr_addr, 70);
    chk("C_start_addr", start_addr, 6);
    for (int i = 1; i <= 447; i++) step(1'b1, 8'd50, 1'b0, 1'b0);
    chk("C_last_addr", wr_addr, 5);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("C_data_ready", data_ready, 1);

    // Long ARMED period with pointer wrap, ignored re-arm, then toggled valid.
    trig_level = 8'd200; trig_edge = 1'b0;
    step(1'b0, 8'd0, 1'b1, 1'b0);
    snap = wr_cnt;
    for (int k = 0; k < 664; k++) begin
      step(1'b1, 8'd10, (k == 300), 1'b0);
      if (k == 511) chk("D_addr_511", wr_addr, 511);
      if (k == 512) chk("D_addr_wrap0", wr_addr, 0);
    end
    step(1'b1, 8'd250, 1'b0, 1'b0);
    chk("D_trig_addr", wr_addr, 152);
    chk("D_start_addr", start_addr, 88);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("D_write_count", wr_cnt - snap, 665);
    chk("D_gap_wr_en", wr_en, 0);
    for (int j = 0; j < 5; j++) begin
      step(1'b1, 8'(j), 1'b0, 1'b0);
      chk("D_toggle_wr_en1", wr_en, 1);
      chk("D_toggle_addr", wr_addr, 153 + j);
      step(1'b0, 8'd0, 1'b0, 1'b0);
      chk("D_toggle_wr_en0", wr_en, 0);
    end
    for (int i = 1; i <= 442; i++) step(1'b1, 8'd10, 1'b0, 1'b0);
    chk("D_last_addr", wr_addr, 87);
    step(1'b0, 8'd0, 1'b0, 1'b0);
    chk("D_data_ready", data_ready, 1);
    chk("D_start_hold", start_addr, 88);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_capture_writer.md
ADC_CAPTURE_WRITER -- requirements
Module: adc_capture_writer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 9, meaning the sample buffer address width (depth 512).
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning the ADC sample width.
REQ-003 The block SHALL have parameter PRETRIG, default 64, meaning the number of samples kept before the trigger; legal range 0..2^ADDR_W-1.
REQ-004 clk  input  1  single system clock; all logic on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 adc_data  input  DATA_W  incoming ADC sample.
REQ-007 adc_valid  input  1  adc_data is valid this cycle.
REQ-008 arm  input  1  single-cycle pulse that starts a capture.
REQ-009 trig_level  input  DATA_W  unsigned trigger threshold.
REQ-010 trig_edge  input  1  0 = rising-edge trigger, 1 = falling-edge trigger.
REQ-011 force_trig  input  1  pulse that forces a trigger on the next valid sample.
REQ-012 wr_en  output  1  buffer write strobe.
REQ-013 wr_addr  output  ADDR_W  buffer write address.
REQ-014 wr_data  output  DATA_W  buffer write data.
REQ-015 data_ready  output  1  buffer holds a complete capture; readers may sweep it.
REQ-016 start_addr  output  ADDR_W  buffer address of the oldest sample in the capture.
REQ-017 busy  output  1  capture in progress (any state except IDLE and DONE).

Function
REQ-018 The block SHALL implement states IDLE, PRE, ARMED, POST, DONE.
REQ-019 IDLE/DONE + arm: SHALL go to PRE (to ARMED if PRETRIG=0), clear data_ready, and reset the write pointer and the sample counter to 0.
REQ-020 arm while busy SHALL be ignored.
REQ-021 Every valid sample in PRE, ARMED or POST SHALL be written: adc_valid in cycle n gives wr_en=1, wr_addr=pointer, wr_data=adc_data in cycle n+1; pointer then increments modulo 2^ADDR_W.
REQ-022 wr_en SHALL be 0 in IDLE and DONE, and in any cycle after a cycle with adc_valid=0.
REQ-023 PRE SHALL count PRETRIG valid samples and then go to ARMED; trigger conditions in PRE SHALL be ignored.
REQ-024 The trigger SHALL be evaluated in ARMED only, on valid samples, against the previous valid sample p and the current sample c (unsigned compare).
REQ-025 Rising trigger SHALL be p < trig_level and c >= trig_level; falling trigger SHALL be p > trig_level and c <= trig_level.
REQ-026 The first valid sample after arm SHALL have no predecessor and SHALL NOT produce an edge trigger.
REQ-027 force_trig pulsed in ARMED SHALL be latched, and the next valid sample SHALL be the trigger sample; force_trig outside ARMED SHALL be ignored.
REQ-028 The trigger sample at address T SHALL be written, and start_addr SHALL become (T - PRETRIG) mod 2^ADDR_W.
REQ-029 After the trigger, the state SHALL be POST.
REQ-030 POST SHALL write 2^ADDR_W - PRETRIG - 1 further valid samples and then go to DONE; the total written since T SHALL equal 2^ADDR_W - PRETRIG.
REQ-031 ARMED SHALL keep overwriting circularly until the trigger; the pointer SHALL wrap 511->0 with no stall.
REQ-032 data_ready SHALL assert in the cycle after the final POST write and SHALL hold until the next accepted arm.
REQ-033 start_addr SHALL hold its value from trigger until the next trigger or reset.
REQ-034 If arm and force_trig are high together in IDLE, only arm SHALL act.

Reset
REQ-035 While reset is high, the block SHALL go to IDLE and hold wr_en=0, wr_addr=0, wr_data=0, data_ready=0, start_addr=0, busy=0, pointer=0, counters=0 and the force latch cleared.
REQ-036 Reset mid-capture SHALL abandon the capture, and data_ready SHALL stay 0 until a new capture completes.

Verification
REQ-037 PRETRIG=64, samples 0,1,2,... every cycle, arm, rising trig_level=100 -> T=100, start_addr=36, 448 writes from T, data_ready high after the write at address 35.
REQ-038 Ramp 255 down to 0, trig_edge=1, trig_level=128, PRETRIG=64 -> trigger on sample value 128; start_addr=(T-64) mod 512.
REQ-039 Constant sample 50, force_trig during ARMED -> next valid sample is the trigger sample; force_trig during PRE -> no effect.
REQ-040 Long ARMED period (>600 samples) then trigger -> wr_addr wraps 511->0, start_addr is computed modulo 512, and no write is missing.
REQ-041 adc_valid toggling 1,0,1,0 -> wr_en follows with 1-cycle latency; addresses are contiguous.
REQ-042 Reset in POST after 200 writes -> all outputs 0 and state IDLE; arm plus a full capture then gives data_ready=1.
